// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the core memory path: opcodes, ALU operations,
// memory access sizes and the arbiter response states.
package mem_arbiter_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ALU   = 4'd1,
    OP_ALUI  = 4'd2,
    OP_LOAD  = 4'd3,
    OP_STORE = 4'd4,
    OP_BRANCH = 4'd5,
    OP_JUMP  = 4'd6
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } resp_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive cycles a pending fetch was refused; flags when the
// count reaches its limit so the arbiter can hand the fetch a turn.
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic starved
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!if_req || if_gnt) begin
      count <= '0;
    end else if (count != CW'(STARVE_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign starved = (count == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch vs load/store) with a one-cycle read
// response path. Define MEMARB_STARVE_GUARD_EN to stop fetches starving.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AWIDTH-1:0] dm_addr_i,
  input  logic [DWIDTH-1:0] dm_wdata_i,
  input  logic [1:0]        dm_size_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DWIDTH-1:0] dm_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [1:0]        mem_size_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              stall_if_o
);

  resp_state_e state;
  logic        starve_hit;

`ifdef MEMARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req_i),
    .if_gnt (if_gnt_o),
    .starved(starve_hit)
  );
`else
  // Strict data priority: the override can never fire and STARVE_MAX is inert.
  assign starve_hit = (STARVE_MAX < 0);
`endif

  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    if (reset) begin
      if (dm_req_i && !(if_req_i && starve_hit)) begin
        dm_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_size_o  = '0;
    if (if_gnt_o) begin
      mem_re_o   = 1'b1;
      mem_addr_o = if_addr_i;
      mem_size_o = SIZE_WORD;
    end else if (dm_gnt_o) begin
      mem_re_o    = !dm_we_i;
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      mem_size_o  = dm_size_i;
    end
  end

  // Remember whose read is in flight; stores finish in the grant cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (if_gnt_o) begin
      state <= RESP_IF;
    end else if (dm_gnt_o && !dm_we_i) begin
      state <= RESP_DM;
    end else begin
      state <= IDLE;
    end
  end

  assign if_rvalid_o = (state == RESP_IF);
  assign dm_rvalid_o = (state == RESP_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  assign stall_if_o  = reset && if_req_i && !if_gnt_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic, all checked against a rule-level reference model.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam bit GuardOn = 1'b1;
`else
  localparam bit GuardOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic [1:0]    dm_size_i;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_re_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [1:0]    mem_size_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_if_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_size_i(dm_size_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_rdata_i(mem_rdata_i), .stall_if_o(stall_if_o)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: refused-fetch streak and owner of the read in flight
  // (0 = nobody, 1 = fetch, 2 = data).
  int starveCnt = 0;
  int pendResp  = 0;
  int ifGrants  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_gnt"}, 32'(if_gnt_o), 32'd0);
    checkOutput({tag, "_dm_gnt"}, 32'(dm_gnt_o), 32'd0);
    checkOutput({tag, "_if_rvalid"}, 32'(if_rvalid_o), 32'd0);
    checkOutput({tag, "_dm_rvalid"}, 32'(dm_rvalid_o), 32'd0);
    checkOutput({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    checkOutput({tag, "_dm_rdata"}, dm_rdata_o, 32'd0);
    checkOutput({tag, "_mem_re"}, 32'(mem_re_o), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    checkOutput({tag, "_mem_size"}, 32'(mem_size_o), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall_if_o), 32'd0);
  endtask

  // Drive one cycle of requests, check every output mid-cycle, then advance
  // the model across the rising edge.
  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dmReq, input logic dmWe,
                               input logic [31:0] dmAddr, input logic [31:0] dmWdata,
                               input logic [1:0] dmSize, input logic [31:0] rdata);
    logic expIf, expDm;
    if_req_i    = ifReq;
    if_addr_i   = ifAddr;
    dm_req_i    = dmReq;
    dm_we_i     = dmWe;
    dm_addr_i   = dmAddr;
    dm_wdata_i  = dmWdata;
    dm_size_i   = dmSize;
    mem_rdata_i = rdata;
    expDm = dmReq && !(ifReq && GuardOn && starveCnt == SMAX);
    expIf = ifReq && !expDm;
    @(negedge clk);
    checkOutput("if_gnt", 32'(if_gnt_o), 32'(expIf));
    checkOutput("dm_gnt", 32'(dm_gnt_o), 32'(expDm));
    checkOutput("stall_if", 32'(stall_if_o), 32'(ifReq && !expIf));
    checkOutput("mem_re", 32'(mem_re_o), 32'(expIf || (expDm && !dmWe)));
    checkOutput("mem_we", 32'(mem_we_o), 32'(expDm && dmWe));
    checkOutput("mem_addr", mem_addr_o, expIf ? ifAddr : (expDm ? dmAddr : 32'd0));
    checkOutput("mem_wdata", mem_wdata_o, expDm ? dmWdata : 32'd0);
    checkOutput("mem_size", 32'(mem_size_o), expIf ? 32'd2 : (expDm ? 32'(dmSize) : 32'd0));
    checkOutput("if_rvalid", 32'(if_rvalid_o), 32'(pendResp == 1));
    checkOutput("if_rdata", if_rdata_o, (pendResp == 1) ? rdata : 32'd0);
    checkOutput("dm_rvalid", 32'(dm_rvalid_o), 32'(pendResp == 2));
    checkOutput("dm_rdata", dm_rdata_o, (pendResp == 2) ? rdata : 32'd0);
    if (expIf) ifGrants++;
    pendResp  = expIf ? 1 : ((expDm && !dmWe) ? 2 : 0);
    starveCnt = (ifReq && !expIf) ? ((starveCnt < SMAX) ? starveCnt + 1 : SMAX) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic [31:0] rdata);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, rdata);
  endtask

  initial begin
    int grantsBefore;
    reset = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h1234; dm_req_i = 1'b1; dm_we_i = 1'b1;
    dm_addr_i = 32'h5678; dm_wdata_i = 32'h9ABC; dm_size_i = 2'd2;
    mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    // Single fetch, then its response.
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'h0);
    idleCycle(32'hCAFE_0001);

    // Simultaneous requests: the load wins and the fetch stalls.
    applyStimulus(1'b1, 32'h1004, 1'b1, 1'b0, 32'h2004, 32'd0, 2'd2, 32'h0);
    idleCycle(32'hCAFE_0002);

    // Store completes in its grant cycle with no response.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h2008, 32'hDEAD_BEEF, 2'd2, 32'h0);
    idleCycle(32'hCAFE_0003);

    // Continuous contention: with the guard, the fetch gets the 5th cycle.
    grantsBefore = ifGrants;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h1100 + 32'(i * 4), 1'b1, 1'b0, 32'h2100 + 32'(i * 4),
                    32'd0, 2'd2, 32'hB000_0000 + 32'(i));
      checkOutput("starve_if_gnt_count", 32'(ifGrants - grantsBefore),
                  (GuardOn && i >= 4) ? 32'd1 : 32'd0);
    end
    idleCycle(32'hCAFE_0004);

    // Reset lands in the response cycle of a fetch.
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 32'h0);
    reset = 1'b0;
    mem_rdata_i = 32'h5555_AAAA;
    dm_req_i = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    @(posedge clk);
    #1 reset = 1'b1;
    pendResp  = 0;
    starveCnt = 0;
    idleCycle(32'h7777_7777);

    // Alternating fetch and load, one access per cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        applyStimulus(1'b1, 32'h4000 + 32'(i * 4), 1'b0, 1'b0, 32'd0, 32'd0, 2'd0,
                      32'hA000_0000 + 32'(i));
      else
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h5000 + 32'(i * 4), 32'd0, 2'd1,
                      32'hA000_0000 + 32'(i));
    end
    idleCycle(32'hCAFE_0005);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 2)), $urandom);
    end
    idleCycle(32'hCAFE_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DWIDTH, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the number of consecutive denied fetch cycles that forces a fetch grant.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  AWIDTH  fetch address.
- if_gnt_o  out  1  fetch granted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DWIDTH  fetch read data.
- dm_req_i  in  1  load/store request.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  AWIDTH  data address.
- dm_wdata_i  in  DWIDTH  store data.
- dm_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word.
- dm_gnt_o  out  1  data granted this cycle.
- dm_rvalid_o  out  1  load data valid.
- dm_rdata_o  out  DWIDTH  load data.
- mem_re_o, mem_we_o  out  1 each  memory read and write strobes.
- mem_addr_o  out  AWIDTH  memory address.
- mem_wdata_o  out  DWIDTH  memory write data.
- mem_size_o  out  2  memory access size.
- mem_rdata_i  in  DWIDTH  memory read data, valid one cycle after mem_re_o.
- stall_if_o  out  1  equals if_req_i && !if_gnt_o.

Function
REQ-005 SHALL grant at most one requester per cycle; grants are combinational from the current requests and state.
REQ-006 When both requesters are active, the data requester SHALL win, unless the starve counter equals STARVE_MAX.
REQ-007 The winner's address, data, size and strobe SHALL drive mem_*_o in the grant cycle. With no grant, mem_re_o and mem_we_o SHALL be 0 and the other mem_*_o outputs SHALL be 0.
REQ-008 A fetch grant SHALL force mem_re_o = 1 and mem_size_o = 2.
REQ-009 The response FSM SHALL have states IDLE, RESP_IF and RESP_DM. The next state is set on each edge:
- RESP_IF after a fetch grant.
- RESP_DM after a load grant.
- IDLE otherwise, including after a store grant.
REQ-010 In RESP_IF, if_rvalid_o SHALL be 1 and if_rdata_o SHALL equal mem_rdata_i. RESP_DM behaves the same on the dm_* outputs. In all other cases rvalid = 0 and rdata = 0.
REQ-011 A new grant SHALL be accepted in the same cycle a response is delivered, giving back-to-back throughput of one access per cycle.
REQ-012 A store SHALL complete in its grant cycle and SHALL NOT produce dm_rvalid_o.
REQ-013 Starve counter (width clog2(STARVE_MAX+1)):
- increments when if_req_i && !if_gnt_o, saturating at STARVE_MAX;
- clears when if_gnt_o = 1 or if_req_i = 0.
REQ-014 A request dropped before it is granted SHALL leave no state change other than the starve-counter rule.

Reset
REQ-015 While reset = 0:
- the FSM SHALL be in IDLE and the starve counter SHALL be 0;
- all outputs SHALL be 0.
REQ-016 Asserting reset while a response is pending SHALL discard that response; no rvalid SHALL appear in the first cycle after reset is released.

Configuration
REQ-017 Macro MEMARB_STARVE_GUARD_EN:
- When defined, the starve counter and the override in REQ-006 SHALL be present.
- When undefined, the counter SHALL be removed and data SHALL have strict priority. STARVE_MAX is then ignored.

Structure
REQ-018 The FSM state enum (IDLE, RESP_IF, RESP_DM) and the access-size encodings SHALL live in the shared constants package, alongside the existing opcode and ALU encodings.
REQ-019 The starve counter SHALL be the sub-module arb_starve_counter, instantiated only under MEMARB_STARVE_GUARD_EN.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Only if_req_i = 1, addr 0x1000 -> if_gnt_o = 1, mem_re_o = 1, mem_addr_o = 0x1000. Next cycle if_rvalid_o = 1 and if_rdata_o = mem_rdata_i.
- Both requests at the same time, dm load at 0x2004 -> dm_gnt_o = 1, if_gnt_o = 0, stall_if_o = 1. Next cycle dm_rvalid_o = 1 and if_rvalid_o = 0.
- Store (dm_we_i = 1, data 0xDEADBEEF, size 2) -> mem_we_o = 1, mem_wdata_o = 0xDEADBEEF. Next cycle dm_rvalid_o = 0.
- With the guard enabled, both requesting continuously, STARVE_MAX = 4 -> dm granted for 4 cycles, if granted on the 5th, then dm again.
- Fetch granted, then reset = 0 in the response cycle, then released -> no rvalid, all outputs 0, FSM in IDLE.
- Alternating fetch and load every cycle -> one grant and one rvalid per cycle, each response routed to the requester granted in the previous cycle.
